x_500_mod_4051_check: RTL

Streaming residue-code checker for 500-bit operands protected by a mod-4051 check residue. It is the receiving end of the residue path: the combinational mod-4051 reducer generates the 12-bit residue at the sender. This block accepts the operand as 12-bit words, most significant word first, followed by the transmitted residue. It recomputes X mod 4051 by Horner accumulation, compares the result with the received residue, and reports pass/fail per frame through a valid/ready handshake.

---
 rtl/x_500_mod_4051_check_pkg.sv | 18 +
 rtl/mod_4051_fold.sv | 28 ++
 rtl/x_500_mod_4051_check.sv | 120 ++++++++++++
 3 files changed

// File: rtl/x_500_mod_4051_check_pkg.sv
// Shared constants and types for the mod-4051 residue path.
//   MOD4051 : residue modulus
//   R2_12   : 2^12 mod 4051, weight of one 12-bit word shift
//   WORDS   : operand words per frame
//   state_e : checker FSM states
package x_500_mod_4051_check_pkg;

    localparam logic [11:0] MOD4051 = 12'd4051;
    localparam logic [5:0]  R2_12   = 6'd45;
    localparam int unsigned WORDS   = 42;

    typedef enum logic [1:0] {
        ACCUM  = 2'd0,
        CHK    = 2'd1,
        REPORT = 2'd2
    } state_e;

endpackage

// File: rtl/mod_4051_fold.sv
// Combinational reduction of an 18-bit value to its canonical residue mod 4051.
// Correct for any 18-bit input.
//   i_t   : 18-bit value to reduce
//   o_res : i_t mod 4051, always 0..4050
module mod_4051_fold
    import x_500_mod_4051_check_pkg::*;
(
    input  logic [17:0] i_t,
    output logic [11:0] o_res
);

    logic [11:0] w_hi_prod;
    logic [12:0] w_t1;
    logic [12:0] w_t2;
    logic [12:0] w_mod_ext;

    assign w_mod_ext = {1'b0, MOD4051};

    // Upper 6 bits carry weight 2^12 == 45 (mod 4051).
    assign w_hi_prod = 12'(i_t[17:12]) * 12'(R2_12);
    assign w_t1      = {1'b0, i_t[11:0]} + {1'b0, w_hi_prod};

    // Second fold of the single carry bit; result stays below 2*4051.
    assign w_t2 = {1'b0, w_t1[11:0]} + (w_t1[12] ? 13'(R2_12) : 13'd0);

    assign o_res = (w_t2 >= w_mod_ext) ? 12'(w_t2 - w_mod_ext) : w_t2[11:0];

endmodule

// File: rtl/x_500_mod_4051_check.sv
// Streaming residue checker for 500-bit operands with a mod-4051 check residue.
// Accepts 42 operand words (MS word first) then the received residue, recomputes
// X mod 4051 by Horner accumulation and reports pass/fail per frame.
//   clk, rst     : clock, asynchronous active-high reset
//   in_valid/in_ready/in_data   : 12-bit beat input
//   out_valid/out_ready         : result handshake
//   out_ok       : residue matches and frame well-formed
//   out_fmt_err  : word 0 upper nibble set, or received residue >= 4051
//   out_residue  : computed X mod 4051
module x_500_mod_4051_check
    import x_500_mod_4051_check_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [11:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_ok,
    output logic        out_fmt_err,
    output logic [11:0] out_residue
);

    state_e      r_state;
    state_e      w_state_nxt;
    logic [5:0]  r_cnt;
    logic [11:0] r_acc;
    logic        r_fmt;
    logic        r_ok;
    logic        r_fmt_err;
    logic [11:0] r_residue;

    logic        w_fire;
    logic [11:0] w_acc_in;
    logic [17:0] w_t;
    logic [11:0] w_fold;
    logic        w_r_big;

    // in_ready is gated by rst so it reads 0 while reset is held.
    assign in_ready  = ~rst & (r_state != REPORT);
    assign out_valid = (r_state == REPORT);
    assign w_fire    = in_valid & in_ready;

    // Beat 0 starts from an empty accumulator.
    assign w_acc_in = (r_cnt == 6'd0) ? 12'd0 : r_acc;
    assign w_t      = 18'(w_acc_in) * 18'(R2_12) + 18'(in_data);
    assign w_r_big  = (in_data >= MOD4051);

    mod_4051_fold u_fold (
        .i_t   (w_t),
        .o_res (w_fold)
    );

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ACCUM:   if (w_fire && r_cnt == 6'(WORDS - 1)) w_state_nxt = CHK;
            CHK:     if (w_fire) w_state_nxt = REPORT;
            REPORT:  if (out_ready) w_state_nxt = ACCUM;
            default: w_state_nxt = ACCUM;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ACCUM;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= 6'd0;
            r_acc     <= 12'd0;
            r_fmt     <= 1'b0;
            r_ok      <= 1'b0;
            r_fmt_err <= 1'b0;
            r_residue <= 12'd0;
        end else begin
            unique case (r_state)
                ACCUM: begin
                    if (w_fire) begin
                        r_acc <= w_fold;
                        r_cnt <= r_cnt + 6'd1;
                        // Word 0 only carries 8 significant bits.
                        if (r_cnt == 6'd0 && in_data[11:8] != 4'd0) begin
                            r_fmt <= 1'b1;
                        end
                    end
                end
                CHK: begin
                    if (w_fire) begin
                        r_cnt     <= r_cnt + 6'd1;
                        r_ok      <= (in_data == r_acc) & ~r_fmt & ~w_r_big;
                        r_fmt_err <= r_fmt | w_r_big;
                        r_fmt     <= r_fmt | w_r_big;
                        r_residue <= r_acc;
                    end
                end
                REPORT: begin
                    if (out_ready) begin
                        r_acc <= 12'd0;
                        r_cnt <= 6'd0;
                        r_fmt <= 1'b0;
                    end
                end
                default: begin
                    r_cnt <= 6'd0;
                end
            endcase
        end
    end

    assign out_ok      = r_ok;
    assign out_fmt_err = r_fmt_err;
    assign out_residue = r_residue;

endmodule
